// File: rtl/fetch_pkg.sv
// Shared constants, occupancy state encoding and the fixed instruction ROM
// contents for the instruction fetch buffer.
package fetch_pkg;

    localparam int PC_W_DEF    = 5;
    localparam int INSTR_W_DEF = 8;
    localparam int FIFO_DEPTH  = 2;

    localparam logic [7:0] ROM_XOR = 8'h5A;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    // Instruction word stored at a given address for the default widths.
    function automatic logic [INSTR_W_DEF-1:0] rom_lookup(input logic [PC_W_DEF-1:0] addr);
        return {addr[2:0], addr} ^ ROM_XOR;
    endfunction

endpackage

// File: rtl/fetch_rom.sv
// Combinational instruction ROM: the word is derived from the address as
// {a[2:0], a} XOR 0x5A, resized to the instruction width.
module fetch_rom
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic [PC_W-1:0]    pc_i,
    output logic [INSTR_W-1:0] instr_o
);

    generate
        if (PC_W == PC_W_DEF && INSTR_W == INSTR_W_DEF) begin : g_default
            assign instr_o = rom_lookup(pc_i);
        end else begin : g_generic
            logic [PC_W+2:0] cat_s;
            assign cat_s   = {pc_i[2:0], pc_i};
            assign instr_o = INSTR_W'(cat_s) ^ INSTR_W'(ROM_XOR);
        end
    endgenerate

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Two-entry fetch buffer: accepted PCs are looked up in the ROM and queued
// with their PC. Optional head parity output when FETCH_PARITY_EN is defined.
module instruction_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               out_ready,
`ifdef FETCH_PARITY_EN
    output logic               instr_par,
`endif
    output logic [7:0]         fetch_count
);

    occ_state_e         state_q, state_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [7:0]         count_q, count_d;
    logic [PC_W-1:0]    pc_mem_q    [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [FIFO_DEPTH];
    logic [INSTR_W-1:0] rom_s;
    logic               push_s;
    logic               pop_s;

    fetch_rom #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_rom (
        .pc_i    (pc_in),
        .instr_o (rom_s)
    );

    // Handshake status comes only from registered state, never from out_ready.
    assign pc_ready    = (state_q != OCC_FULL);
    assign instr_valid = (state_q != OCC_EMPTY);
    assign push_s      = pc_valid & pc_ready & ~flush;
    assign pop_s       = instr_valid & out_ready & ~flush;

    assign instr_out   = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign fetch_count = count_q;

    // Occupancy, pointer and counter next-state; flush overrides push and pop.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            state_d  = OCC_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ~wr_ptr_q;
                count_d  = count_q + 8'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case (state_q)
                OCC_EMPTY: begin
                    if (push_s) state_d = OCC_ONE;
                    else        state_d = OCC_EMPTY;
                end
                OCC_ONE: begin
                    if (push_s && !pop_s)      state_d = OCC_FULL;
                    else if (pop_s && !push_s) state_d = OCC_EMPTY;
                    else                       state_d = OCC_ONE;
                end
                OCC_FULL: begin
                    if (pop_s) state_d = OCC_ONE;
                    else       state_d = OCC_FULL;
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]    <= pc_in;
            instr_mem_q[wr_ptr_q] <= rom_s;
        end
    end

`ifdef FETCH_PARITY_EN
    logic par_mem_q [FIFO_DEPTH];

    assign instr_par = par_mem_q[rd_ptr_q];

    // Parity is computed once at push and travels with its entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                par_mem_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            par_mem_q[wr_ptr_q] <= ^{pc_in, rom_s};
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed self-checking bench for instruction_fetch_buffer.
module tb_instruction_fetch_buffer;

    logic       clk;
    logic       reset;
    logic [4:0] pc_in;
    logic       pc_valid;
    logic       pc_ready;
    logic       flush;
    logic [7:0] instr_out;
    logic [4:0] instr_pc;
    logic       instr_valid;
    logic       out_ready;
    logic [7:0] fetch_count;
`ifdef FETCH_PARITY_EN
    logic       instr_par;
`endif

    int vectors;
    int miscompares;

    instruction_fetch_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .out_ready   (out_ready),
`ifdef FETCH_PARITY_EN
        .instr_par   (instr_par),
`endif
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc_in = 5'd0; pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #3;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", pc_ready); end
        vectors++; if (instr_out !== 8'h00) begin miscompares++; $display("FAIL reset_instr: got %h expected 00", instr_out); end
        vectors++; if (instr_pc !== 5'd0) begin miscompares++; $display("FAIL reset_pc: got %0d expected 0", instr_pc); end
        vectors++; if (fetch_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
`ifdef FETCH_PARITY_EN
        vectors++; if (instr_par !== 1'b0) begin miscompares++; $display("FAIL reset_par: got %b expected 0", instr_par); end
`endif
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1; pc_in = 5'd3; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", instr_valid); end
        vectors++; if (instr_out !== 8'h39) begin miscompares++; $display("FAIL single_instr: got %h expected 39", instr_out); end
        vectors++; if (instr_pc !== 5'd3) begin miscompares++; $display("FAIL single_pc: got %0d expected 3", instr_pc); end
        vectors++; if (fetch_count !== 8'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", fetch_count); end
        tick();
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: got %b expected 0", instr_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; pc_valid = 1'b1; pc_in = 5'd0;
        tick();
        vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one: got %b expected 1", pc_ready); end
        pc_in = 5'd1;
        tick();
        vectors++; if (pc_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b expected 0", pc_ready); end
        vectors++; if (instr_out !== 8'h5A) begin miscompares++; $display("FAIL b2b_head0: got %h expected 5a", instr_out); end
        pc_in = 5'd2;
        tick();
        vectors++; if (instr_out !== 8'h5A || instr_pc !== 5'd0) begin miscompares++; $display("FAIL b2b_stable: got %h/%0d expected 5a/0", instr_out, instr_pc); end
        vectors++; if (fetch_count !== 8'd3) begin miscompares++; $display("FAIL b2b_count_held: got %0d expected 3", fetch_count); end
        out_ready = 1'b1;
        tick();
        vectors++; if (instr_out !== 8'h7B || instr_pc !== 5'd1) begin miscompares++; $display("FAIL b2b_head1: got %h/%0d expected 7b/1", instr_out, instr_pc); end
        vectors++; if (pc_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop: got %b expected 1", pc_ready); end
        tick();
        pc_valid = 1'b0;
        vectors++; if (instr_out !== 8'h18 || instr_pc !== 5'd2) begin miscompares++; $display("FAIL b2b_head2: got %h/%0d expected 18/2", instr_out, instr_pc); end
        vectors++; if (fetch_count !== 8'd4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", fetch_count); end
        tick();
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b expected 0", instr_valid); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0; pc_valid = 1'b1; pc_in = 5'd5;
        tick();
        vectors++; if (instr_out !== 8'hFF) begin miscompares++; $display("FAIL pp_head5: got %h expected ff", instr_out); end
        pc_in = 5'd31; out_ready = 1'b1;
        tick();
        pc_valid = 1'b0;
        vectors++; if (instr_out !== 8'hA5 || instr_pc !== 5'd31) begin miscompares++; $display("FAIL pp_head31: got %h/%0d expected a5/31", instr_out, instr_pc); end
        vectors++; if (pc_ready !== 1'b1 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL pp_state_one: got ready=%b valid=%b expected 1/1", pc_ready, instr_valid); end
        vectors++; if (fetch_count !== 8'd6) begin miscompares++; $display("FAIL pp_count: got %0d expected 6", fetch_count); end
        tick();
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL pp_drain: got %b expected 0", instr_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; pc_valid = 1'b1; pc_in = 5'd4;
        tick();
        pc_in = 5'd6;
        tick();
        vectors++; if (pc_ready !== 1'b0 || instr_out !== 8'hDE) begin miscompares++; $display("FAIL fl_full: got ready=%b head=%h expected 0/de", pc_ready, instr_out); end
        flush = 1'b1; pc_in = 5'd7;
        tick();
        flush = 1'b0;
        vectors++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin miscompares++; $display("FAIL fl_full_flush: got valid=%b ready=%b expected 0/1", instr_valid, pc_ready); end
        vectors++; if (fetch_count !== 8'd8) begin miscompares++; $display("FAIL fl_count_full: got %0d expected 8", fetch_count); end
        pc_in = 5'd7;
        tick();
        vectors++; if (instr_out !== 8'hBD || fetch_count !== 8'd9) begin miscompares++; $display("FAIL fl_push7: got %h/%0d expected bd/9", instr_out, fetch_count); end
        flush = 1'b1; out_ready = 1'b1; pc_in = 5'd9;
        tick();
        flush = 1'b0;
        vectors++; if (instr_valid !== 1'b0 || fetch_count !== 8'd9) begin miscompares++; $display("FAIL fl_one_flush: got valid=%b count=%0d expected 0/9", instr_valid, fetch_count); end
        out_ready = 1'b0;
        tick();
        pc_valid = 1'b0;
        vectors++; if (instr_out !== 8'h73 || instr_pc !== 5'd9 || fetch_count !== 8'd10) begin miscompares++; $display("FAIL fl_after: got %h/%0d/%0d expected 73/9/10", instr_out, instr_pc, fetch_count); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap_and_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        out_ready = 1'b1; pc_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            pc_in = 5'(i);
            tick();
        end
        vectors++; if (fetch_count !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d expected 255", fetch_count); end
        pc_in = 5'd2;
        tick();
        vectors++; if (fetch_count !== 8'd0) begin miscompares++; $display("FAIL wrap_0: got %0d expected 0", fetch_count); end
        vectors++; if (instr_out !== 8'h18 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_head: got %h/%b expected 18/1", instr_out, instr_valid); end
        reset = 1'b0;
        #2;
        vectors++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1 || instr_out !== 8'h00 || instr_pc !== 5'd0 || fetch_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b ready=%b instr=%h pc=%0d count=%0d expected 0/1/00/0/0", instr_valid, pc_ready, instr_out, instr_pc, fetch_count);
        end
        reset = 1'b1; pc_in = 5'd3;
        tick();
        pc_valid = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr_out !== 8'h39 || fetch_count !== 8'd1) begin miscompares++; $display("FAIL first_accept: got %b/%h/%0d expected 1/39/1", instr_valid, instr_out, fetch_count); end
        tick();
    endtask

`ifdef FETCH_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b0; pc_valid = 1'b1; pc_in = 5'd1;
        tick();
        pc_in = 5'd0;
        tick();
        pc_valid = 1'b0;
        vectors++; if (instr_par !== 1'b1) begin miscompares++; $display("FAIL par_pc1: got %b expected 1", instr_par); end
        out_ready = 1'b1;
        tick();
        vectors++; if (instr_par !== 1'b0) begin miscompares++; $display("FAIL par_pc0: got %b expected 0", instr_par); end
        tick();
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_push_pop();
        test_flush();
`ifdef FETCH_PARITY_EN
        test_parity();
`endif
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
